// File: rtl/wb_exmem_ctrl_if.sv
// Wishbone slave bus bundle for the external-memory model (wb_exmem_ctrl).
interface wb_exmem_ctrl_if #(
    parameter int BITS = 32
) ();
    logic                  wbs_cyc_i;
    logic                  wbs_stb_i;
    logic                  wbs_we_i;
    logic [BITS/8-1:0]     wbs_sel_i;
    logic [31:0]           wbs_adr_i;
    logic [BITS-1:0]       wbs_dat_i;
    logic                  wbs_ack_o;
    logic [BITS-1:0]       wbs_dat_o;

    modport master (
        output wbs_cyc_i, wbs_stb_i, wbs_we_i, wbs_sel_i, wbs_adr_i, wbs_dat_i,
        input  wbs_ack_o, wbs_dat_o
    );

    modport slave (
        input  wbs_cyc_i, wbs_stb_i, wbs_we_i, wbs_sel_i, wbs_adr_i, wbs_dat_i,
        output wbs_ack_o, wbs_dat_o
    );
endinterface

// File: rtl/wb_exmem_ctrl.sv
// Wishbone slave modelling wait-stated external memory in the 0x38xx_xxxx window.
// Optional access counters are enabled by defining WB_EXMEM_STATS_EN.
module wb_exmem_ctrl #(
    parameter int         BITS   = 32,
    parameter int         DELAYS = 10,
    parameter int         DEPTH  = 1024,
    parameter logic [7:0] BASE   = 8'h38
) (
    input  logic                  wb_clk_i,
    input  logic                  wb_rstn_i,
    wb_exmem_ctrl_if.slave        wbs,
`ifdef WB_EXMEM_STATS_EN
    output logic [15:0]           rd_cnt_o,
    output logic [15:0]           wr_cnt_o,
`endif
    output logic                  busy_o
);
    localparam int AW = $clog2(DEPTH);
    localparam int SW = BITS / 8;
    localparam int HW = 22 - AW;
    localparam int CW = (DELAYS > 0) ? $clog2(DELAYS + 1) : 1;
    localparam logic [CW-1:0] CNT_LOAD = CW'(DELAYS);
    localparam logic [CW-1:0] CNT_ZERO = CW'(0);
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        ACK  = 2'd2
    } state_t;

    state_t            state_r;
    logic [CW-1:0]     cnt_r;
    logic [AW-1:0]     idx_r;
    logic              we_r;
    logic [SW-1:0]     sel_r;
    logic [BITS-1:0]   wdat_r;
    logic              in_range_r;
    logic              ack_r;
    logic [BITS-1:0]   rdat_r;
    logic              busy_r;
    logic              in_range_s;
    logic              mem_we_s;
    logic [BITS-1:0]   mem_r [DEPTH];

    function automatic logic [BITS-1:0] merge_lanes(
        input logic [BITS-1:0] old_word,
        input logic [BITS-1:0] new_word,
        input logic [SW-1:0]   lanes
    );
        logic [BITS-1:0] res;
        res = old_word;
        for (int i = 0; i < SW; i++) begin
            if (lanes[i]) begin
                res[8*i +: 8] = new_word[8*i +: 8];
            end else begin
                res[8*i +: 8] = old_word[8*i +: 8];
            end
        end
        return res;
    endfunction

    // Address decode and write strobe; the write lands on the WAIT->ACK edge only.
    always_comb begin
        in_range_s = (wbs.wbs_adr_i[31:24] == BASE) &&
                     (wbs.wbs_adr_i[23:AW+2] == {HW{1'b0}});
        mem_we_s   = 1'b0;
        if (state_r == WAIT && wbs.wbs_cyc_i && cnt_r == CNT_ZERO) begin
            mem_we_s = we_r && in_range_r;
        end else begin
            mem_we_s = 1'b0;
        end
    end

    // Transfer FSM with registered ack, read data and busy.
    always_ff @(posedge wb_clk_i or negedge wb_rstn_i) begin
        if (!wb_rstn_i) begin
            state_r    <= IDLE;
            cnt_r      <= CNT_ZERO;
            idx_r      <= {AW{1'b0}};
            we_r       <= 1'b0;
            sel_r      <= {SW{1'b0}};
            wdat_r     <= {BITS{1'b0}};
            in_range_r <= 1'b0;
            ack_r      <= 1'b0;
            rdat_r     <= {BITS{1'b0}};
            busy_r     <= 1'b0;
        end else begin
            case (state_r)
                IDLE: begin
                    ack_r  <= 1'b0;
                    rdat_r <= {BITS{1'b0}};
                    if (wbs.wbs_cyc_i && wbs.wbs_stb_i) begin
                        idx_r      <= wbs.wbs_adr_i[AW+1:2];
                        we_r       <= wbs.wbs_we_i;
                        sel_r      <= wbs.wbs_sel_i;
                        wdat_r     <= wbs.wbs_dat_i;
                        in_range_r <= in_range_s;
                        cnt_r      <= CNT_LOAD;
                        busy_r     <= 1'b1;
                        state_r    <= WAIT;
                    end else begin
                        busy_r     <= 1'b0;
                    end
                end
                WAIT: begin
                    if (!wbs.wbs_cyc_i) begin
                        busy_r  <= 1'b0;
                        state_r <= IDLE;
                    end else if (cnt_r != CNT_ZERO) begin
                        cnt_r   <= cnt_r - CNT_ONE;
                    end else begin
                        ack_r   <= 1'b1;
                        rdat_r  <= (!we_r && in_range_r) ? mem_r[idx_r] : {BITS{1'b0}};
                        state_r <= ACK;
                    end
                end
                ACK: begin
                    ack_r   <= 1'b0;
                    rdat_r  <= {BITS{1'b0}};
                    busy_r  <= 1'b0;
                    state_r <= IDLE;
                end
                default: begin
                    ack_r   <= 1'b0;
                    rdat_r  <= {BITS{1'b0}};
                    busy_r  <= 1'b0;
                    state_r <= IDLE;
                end
            endcase
        end
    end

    // Storage array; contents survive reset like real external memory.
    always_ff @(posedge wb_clk_i) begin
        if (mem_we_s) begin
            mem_r[idx_r] <= merge_lanes(mem_r[idx_r], wdat_r, sel_r);
        end
    end

    assign wbs.wbs_ack_o = ack_r;
    assign wbs.wbs_dat_o = rdat_r;
    assign busy_o        = busy_r;

`ifdef WB_EXMEM_STATS_EN
    logic [15:0] rd_cnt_r;
    logic [15:0] wr_cnt_r;

    // Saturating counters of completed in-range accesses.
    always_ff @(posedge wb_clk_i or negedge wb_rstn_i) begin
        if (!wb_rstn_i) begin
            rd_cnt_r <= 16'h0000;
            wr_cnt_r <= 16'h0000;
        end else if (state_r == ACK && in_range_r) begin
            if (we_r) begin
                wr_cnt_r <= (wr_cnt_r == 16'hFFFF) ? wr_cnt_r : wr_cnt_r + 16'h0001;
            end else begin
                rd_cnt_r <= (rd_cnt_r == 16'hFFFF) ? rd_cnt_r : rd_cnt_r + 16'h0001;
            end
        end else begin
            rd_cnt_r <= rd_cnt_r;
            wr_cnt_r <= wr_cnt_r;
        end
    end

    assign rd_cnt_o = rd_cnt_r;
    assign wr_cnt_o = wr_cnt_r;
`endif
endmodule
